// File: rtl/muldiv_pkg.sv
// Shared encodings and defaults for the E-stage multiply/divide engine.
package muldiv_pkg;

  localparam int WIDTH_DEFAULT      = 32;
  localparam int DIV_CYCLES_DEFAULT = WIDTH_DEFAULT;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    DONE = 2'b11
  } state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_unit_div_radix2.sv
// Iterative unsigned restoring divider: one quotient bit per enabled cycle.
// quo_o/rem_o present the result of the current step so the caller can capture it on the last one.
module div_radix2
  import muldiv_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEFAULT,
  parameter int DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH:0]   rem_shift_s;
  logic [WIDTH:0]   trial_s;
  logic             ge_s;
  logic [WIDTH-1:0] rem_step_s;
  logic [WIDTH-1:0] quo_step_s;

  // Restoring step: shift in the next dividend bit, keep the difference when it is non-negative.
  always_comb begin
    rem_shift_s = {rem_q, quo_q[WIDTH-1]};
    trial_s     = rem_shift_s - {1'b0, dvs_q};
    ge_s        = ~trial_s[WIDTH];
    if (ge_s) begin
      rem_step_s = trial_s[WIDTH-1:0];
    end else begin
      rem_step_s = rem_shift_s[WIDTH-1:0];
    end
    quo_step_s = {quo_q[WIDTH-2:0], ge_s};
  end

  // Next-state selection for load, step and hold.
  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    if (start_i) begin
      rem_d = {WIDTH{1'b0}};
      quo_d = dividend_i;
      dvs_d = divisor_i;
      cnt_d = {CW{1'b0}};
    end else if (en_i) begin
      rem_d = rem_step_s;
      quo_d = quo_step_s;
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rem_q <= {WIDTH{1'b0}};
      quo_q <= {WIDTH{1'b0}};
      dvs_q <= {WIDTH{1'b0}};
      cnt_q <= {CW{1'b0}};
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign done_o = en_i & (cnt_q == CW'(DIV_CYCLES - 1));
  assign quo_o  = quo_step_s;
  assign rem_o  = rem_step_s;

endmodule

// File: rtl/muldiv_unit.sv
// E-stage MULT/MULTU/DIV/DIVU engine: FSM, single-cycle multiplier and divide sign handling.
// busyE stalls the pipe; result_validE pulses in the cycle the stall releases.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEFAULT,
  parameter int DIV_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             startE,
  input  logic [1:0]       opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             cancelE,
  output logic             busyE,
  output logic             result_validE,
  output logic [WIDTH-1:0] hiE,
  output logic [WIDTH-1:0] loE
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sgn_q, sgn_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;

  logic             accept_s;
  logic             sgn_in_s;
  logic [WIDTH-1:0] a_abs_s;
  logic [WIDTH-1:0] b_abs_s;
  logic [2*WIDTH-1:0] a_ext_s;
  logic [2*WIDTH-1:0] b_ext_s;
  logic [2*WIDTH-1:0] prod_s;
  logic             div_done_s;
  logic [WIDTH-1:0] div_quo_s;
  logic [WIDTH-1:0] div_rem_s;
  logic [WIDTH-1:0] quo_fix_s;
  logic [WIDTH-1:0] rem_fix_s;

  assign accept_s = (state_q == IDLE) & startE & ~cancelE;
  assign sgn_in_s = op_is_signed(opE);
  assign a_abs_s  = (sgn_in_s & srcaE[WIDTH-1]) ? (~srcaE + WIDTH'(1)) : srcaE;
  assign b_abs_s  = (sgn_in_s & srcbE[WIDTH-1]) ? (~srcbE + WIDTH'(1)) : srcbE;

  // Sign- or zero-extending to 2*WIDTH makes one unsigned multiply serve both MULT and MULTU.
  assign a_ext_s   = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q};
  assign b_ext_s   = {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};
  assign prod_s    = a_ext_s * b_ext_s;
  assign quo_fix_s = qneg_q ? (~div_quo_s + WIDTH'(1)) : div_quo_s;
  assign rem_fix_s = rneg_q ? (~div_rem_s + WIDTH'(1)) : div_rem_s;

  div_radix2 #(
    .WIDTH      (WIDTH),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div (
    .clk        (clk),
    .resetn     (resetn),
    .start_i    (accept_s & op_is_div(opE)),
    .en_i       (state_q == DIV),
    .dividend_i (a_abs_s),
    .divisor_i  (b_abs_s),
    .done_o     (div_done_s),
    .quo_o      (div_quo_s),
    .rem_o      (div_rem_s)
  );

  // Stall request; a flush drops it in the same cycle.
  always_comb begin
    if (cancelE) begin
      busyE = 1'b0;
    end else begin
      busyE = ((state_q == IDLE) & startE) | (state_q == MUL) | (state_q == DIV);
    end
  end

  // FSM next state and result capture.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    valid_d = 1'b0;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    if (cancelE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (startE) begin
            sgn_d = sgn_in_s;
            if (op_is_div(opE)) begin
              state_d = DIV;
              qneg_d  = sgn_in_s & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
              rneg_d  = sgn_in_s & srcaE[WIDTH-1];
            end else begin
              state_d = MUL;
              a_d     = srcaE;
              b_d     = srcbE;
            end
          end else begin
            state_d = IDLE;
          end
        end
        MUL: begin
          {hi_d, lo_d} = prod_s;
          valid_d      = 1'b1;
          state_d      = DONE;
        end
        DIV: begin
          if (div_done_s) begin
            hi_d    = rem_fix_s;
            lo_d    = quo_fix_s;
            valid_d = 1'b1;
            state_d = DONE;
          end else begin
            state_d = DIV;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      valid_q <= 1'b0;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      sgn_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign result_validE = valid_q;
  assign hiE           = hi_q;
  assign loE           = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, results, cancel, reset and back-to-back issue.
module tb_muldiv_unit;

  logic        clk;
  logic        resetn;
  logic        startE;
  logic [1:0]  opE;
  logic [31:0] srcaE;
  logic [31:0] srcbE;
  logic        cancelE;
  logic        busyE;
  logic        result_validE;
  logic [31:0] hiE;
  logic [31:0] loE;

  int n_checks;
  int n_fail;
  int n_cyc;
  int n_valid;

  muldiv_unit dut (
    .clk           (clk),
    .resetn        (resetn),
    .startE        (startE),
    .opE           (opE),
    .srcaE         (srcaE),
    .srcbE         (srcbE),
    .cancelE       (cancelE),
    .busyE         (busyE),
    .result_validE (result_validE),
    .hiE           (hiE),
    .loE           (loE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Counts busy cycles starting at the current sample point; operands churn after the start cycle.
  task automatic wait_done(output int n);
    n = 0;
    while (busyE === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
      srcaE = srcaE ^ 32'h5A5A_A5A5;
      srcbE = srcbE ^ 32'h3C3C_C3C3;
      #1;
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int exp_n, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                       input string tag, input bit hold);
    int n;
    @(negedge clk);
    startE = 1'b1;
    opE    = op;
    srcaE  = a;
    srcbE  = b;
    #1;
    wait_done(n);
    check({tag, "_busy_cycles"}, 64'(n), 64'(exp_n));
    check({tag, "_valid"}, 64'(result_validE), 64'd1);
    check({tag, "_hi"}, 64'(hiE), 64'(exp_hi));
    check({tag, "_lo"}, 64'(loE), 64'(exp_lo));
    if (!hold) begin
      startE = 1'b0;
      @(negedge clk);
      #1;
      check({tag, "_valid_drop"}, 64'(result_validE), 64'd0);
      check({tag, "_busy_idle"}, 64'(busyE), 64'd0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    resetn   = 1'b0;
    startE   = 1'b0;
    cancelE  = 1'b0;
    opE      = 2'b00;
    srcaE    = 32'h0;
    srcbE    = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy", 64'(busyE), 64'd0);
    check("reset_valid", 64'(result_validE), 64'd0);
    check("reset_hi", 64'(hiE), 64'd0);
    check("reset_lo", 64'(loE), 64'd0);
    resetn = 1'b1;

    do_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 2,  32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg3x5", 1'b0);
    do_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 2,  32'h0000_0001, 32'hFFFF_FFFE, "multu_max_x2", 1'b0);
    do_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7_2", 1'b0);
    do_op(2'b11, 32'd100,       32'd7,         33, 32'd2,         32'd14,        "divu_100_7", 1'b0);
    do_op(2'b11, 32'd5,         32'd0,         33, 32'd5,         32'hFFFF_FFFF, "divu_by_zero", 1'b0);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0000_0000, 32'h8000_0000, "div_overflow", 1'b0);
    do_op(2'b10, 32'd7,         32'hFFFF_FFFE, 33, 32'h0000_0001, 32'hFFFF_FFFD, "div_7_neg2", 1'b0);

    // Flush on the 10th busy cycle of a DIV.
    @(negedge clk);
    startE = 1'b1;
    opE    = 2'b10;
    srcaE  = 32'd100;
    srcbE  = 32'd7;
    repeat (9) @(negedge clk);
    cancelE = 1'b1;
    #1;
    check("cancel_busy_same_cycle", 64'(busyE), 64'd0);
    @(negedge clk);
    cancelE = 1'b0;
    startE  = 1'b0;
    #1;
    check("cancel_idle_busy", 64'(busyE), 64'd0);
    check("cancel_no_valid", 64'(result_validE), 64'd0);
    check("cancel_hi_hold", 64'(hiE), 64'h1);
    check("cancel_lo_hold", 64'(loE), 64'hFFFF_FFFD);
    n_valid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (result_validE === 1'b1) n_valid++;
    end
    check("cancel_no_late_valid", 64'(n_valid), 64'd0);

    // Reset on the 20th cycle of another DIV.
    @(negedge clk);
    startE = 1'b1;
    opE    = 2'b10;
    srcaE  = 32'hFFFF_FFF9;
    srcbE  = 32'd2;
    repeat (19) @(negedge clk);
    resetn = 1'b0;
    startE = 1'b0;
    @(negedge clk);
    #1;
    check("midreset_busy", 64'(busyE), 64'd0);
    check("midreset_valid", 64'(result_validE), 64'd0);
    check("midreset_hi", 64'(hiE), 64'd0);
    check("midreset_lo", 64'(loE), 64'd0);
    resetn  = 1'b1;
    n_valid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (result_validE === 1'b1) n_valid++;
    end
    check("midreset_no_late_valid", 64'(n_valid), 64'd0);

    // DIVU then MULT with startE held through DONE.
    do_op(2'b11, 32'd100, 32'd7, 33, 32'd2, 32'd14, "b2b_divu", 1'b1);
    @(negedge clk);
    #1;
    check("b2b_single_pulse", 64'(result_validE), 64'd0);
    check("b2b_mult_starts", 64'(busyE), 64'd1);
    opE   = 2'b00;
    srcaE = 32'hFFFF_FFFD;
    srcbE = 32'd5;
    #1;
    wait_done(n_cyc);
    check("b2b_mult_busy_cycles", 64'(n_cyc), 64'd2);
    check("b2b_mult_valid", 64'(result_validE), 64'd1);
    check("b2b_mult_hi", 64'(hiE), 64'hFFFF_FFFF);
    check("b2b_mult_lo", 64'(loE), 64'hFFFF_FFF1);
    startE = 1'b0;
    @(negedge clk);
    #1;
    check("b2b_mult_valid_drop", 64'(result_validE), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
